// File: rtl/estoque_pkg.sv
// Shared state encoding and default sizing for the cork-stock counter.
// Defaults keep the count inside the range the downstream BCD encoders accept.
package estoque_pkg;

    localparam logic [1:0] OCIOSO        = 2'b00;
    localparam logic [1:0] DISPENSA      = 2'b01;
    localparam logic [1:0] ESPERA_LIBERA = 2'b10;
    localparam logic [1:0] REABASTECE    = 2'b11;

    localparam int WIDTH_PADRAO        = 7;
    localparam int MAX_ROLHAS_PADRAO   = 99;
    localparam int LOTE_PADRAO         = 15;
    localparam int LIMIAR_BAIXO_PADRAO = 5;

endpackage

// File: rtl/modulo_detector_borda.sv
// Rising-edge detector: input registered once, pulse is combinational (current high, previous low).
// No backpressure; the pulse lasts one cycle per rising edge.
module modulo_detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic borda
);

    logic anterior;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anterior <= 1'b0;
        end else begin
            anterior <= entrada;
        end
    end

    assign borda = entrada & ~anterior;

endmodule

// File: rtl/modulo_estoque_rolhas.sv
// Cork-stock counter: one cork per capper handshake (ack two edges after the request is sampled),
// saturating batch refill on each refill edge; refill waits while a dispense is in progress.
module modulo_estoque_rolhas
    import estoque_pkg::*;
#(
    parameter int WIDTH        = WIDTH_PADRAO,
    parameter int MAX_ROLHAS   = MAX_ROLHAS_PADRAO,
    parameter int LOTE         = LOTE_PADRAO,
    parameter int LIMIAR_BAIXO = LIMIAR_BAIXO_PADRAO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pedido_rolha,
    input  logic             pedido_reabastece,
    input  logic             limpa_erro,
    output logic             ack_rolha,
    output logic [WIDTH-1:0] reg_r,
    output logic             vazio,
    output logic             nivel_baixo,
    output logic             cheio,
    output logic             erro_falta
);

    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_ROLHAS);
    localparam logic [WIDTH-1:0] LIMIAR_W = WIDTH'(LIMIAR_BAIXO);
    localparam logic [WIDTH:0]   LOTE_X   = (WIDTH+1)'(LOTE);
    localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX_ROLHAS);

    logic [1:0]       estado;
    logic             pedido_q;
    logic             pendente;
    logic             borda_reab;
    logic [WIDTH:0]   soma;
    logic [WIDTH-1:0] reabastecido;

    modulo_detector_borda u_detector (
        .clk     (clk),
        .rst_n   (rst_n),
        .entrada (pedido_reabastece),
        .borda   (borda_reab)
    );

    // One extra bit on the sum so a refill near the ceiling cannot wrap before saturation.
    assign soma         = {1'b0, reg_r} + LOTE_X;
    assign reabastecido = (soma > MAX_X) ? MAX_W : soma[WIDTH-1:0];

    assign vazio       = (reg_r == '0);
    assign nivel_baixo = (reg_r <= LIMIAR_W);
    assign cheio       = (reg_r == MAX_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            reg_r      <= '0;
            ack_rolha  <= 1'b0;
            erro_falta <= 1'b0;
            pendente   <= 1'b0;
            pedido_q   <= 1'b0;
        end else begin
            ack_rolha <= 1'b0;
            pedido_q  <= pedido_rolha;

            // A fresh edge landing on the refill cycle stays pending for another batch.
            if (borda_reab) begin
                pendente <= 1'b1;
            end else if (estado == REABASTECE) begin
                pendente <= 1'b0;
            end

            if ((estado == OCIOSO) && pedido_q && (reg_r == '0)) begin
                erro_falta <= 1'b1;
            end else if (limpa_erro) begin
                erro_falta <= 1'b0;
            end

            case (estado)
                OCIOSO: begin
                    if (pedido_q) begin
                        if (reg_r != '0) begin
                            estado <= DISPENSA;
                        end
                    end else if (pendente) begin
                        estado <= REABASTECE;
                    end
                end
                DISPENSA: begin
                    reg_r     <= reg_r - WIDTH'(1);
                    ack_rolha <= 1'b1;
                    estado    <= ESPERA_LIBERA;
                end
                ESPERA_LIBERA: begin
                    if (!pedido_q) begin
                        estado <= OCIOSO;
                    end
                end
                REABASTECE: begin
                    reg_r  <= reabastecido;
                    estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: doc/modulo_estoque_rolhas.md
Name: modulo_estoque_rolhas

Overview:
- Sequential cork-stock counter feeding the units/tens BCD encoders of the capping station.
- Holds the number of corks in the dispenser (0..MAX_ROLHAS) on reg_r[6:0].
- Releases one cork per handshake with the capper and adds a fixed batch on each refill event.
- Raises empty, low-level and fault flags for the supervisor.

Parameters:
- WIDTH, 7, width of the stock count on reg_r; must match the downstream encoder input.
- MAX_ROLHAS, 99, saturation ceiling; must be ≤ 99 so the downstream BCD encoders stay valid.
- LOTE, 15, corks added per refill event.
- LIMIAR_BAIXO, 5, nivel_baixo asserts when reg_r ≤ this value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- pedido_rolha  in  1  level request from the capper for one cork; held until ack_rolha, then dropped.
- pedido_reabastece  in  1  refill indication; only its rising edge counts.
- limpa_erro  in  1  clears erro_falta.
- ack_rolha  out  1  one-cycle pulse: cork released.
- reg_r  out  WIDTH  current stock count, registered.
- vazio  out  1  reg_r == 0.
- nivel_baixo  out  1  reg_r ≤ LIMIAR_BAIXO.
- cheio  out  1  reg_r == MAX_ROLHAS.
- erro_falta  out  1  sticky flag: a request was made while stock was empty.

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - reg_r = 0, ack_rolha = 0, erro_falta = 0.
  - The pending-refill flag and the edge-detector history are cleared, and the state goes to OCIOSO.
  - vazio = 1, nivel_baixo = 1, cheio = 0.
  - Reset mid-operation aborts any decrement or refill; no ack is emitted.
- vazio, nivel_baixo and cheio decode reg_r combinationally, so they are valid in the same cycle as reg_r.
- Refill edge detection: pedido_reabastece is registered once; a rising edge is prev = 0 and current = 1.
  - Each edge sets the pending flag.
  - Further edges while the flag is pending collapse into it; they do not accumulate.
- FSM states:
  - OCIOSO:
    - pedido_rolha = 1 and reg_r > 0 → DISPENSA.
    - pedido_rolha = 1 and reg_r == 0 → set erro_falta and stay in OCIOSO; no ack is issued.
    - Otherwise, with the pending flag set → REABASTECE.
    - A dispense request has priority over a pending refill.
  - DISPENSA: on the next edge, reg_r ← reg_r − 1 and ack_rolha ← 1 (for one cycle), then → ESPERA_LIBERA.
  - ESPERA_LIBERA: stay while pedido_rolha = 1; → OCIOSO when it reads 0. One cork is released per request assertion.
  - REABASTECE:
    - On the next edge, reg_r ← min(reg_r + LOTE, MAX_ROLHAS) and the pending flag clears; → OCIOSO.
    - The sum is computed WIDTH+1 bits wide, so it cannot wrap around.
- Latency:
  - A request sampled high at edge N gives a decremented reg_r and ack_rolha = 1 after edge N+2.
  - Minimum 4 cycles between consecutive acks; a back-to-back request must pass through OCIOSO.
- A refill edge arriving during DISPENSA or ESPERA_LIBERA stays pending and executes once OCIOSO has no request.
- Refill at cheio: state still passes through REABASTECE, reg_r stays at MAX_ROLHAS, and the pending flag clears.
- erro_falta:
  - Sets on any OCIOSO cycle with a request while empty; otherwise it holds until limpa_erro = 1.
  - If set and clear happen in the same cycle, set wins.
- reg_r never leaves 0..MAX_ROLHAS: no underflow (decrement is only reachable with reg_r > 0) and no overflow (saturation).

Decomposition:
- Package estoque_pkg holds:
  - state encoding: OCIOSO = 2'b00, DISPENSA = 2'b01, ESPERA_LIBERA = 2'b10, REABASTECE = 2'b11;
  - default constants for MAX_ROLHAS, LOTE and LIMIAR_BAIXO.
- One sub-module: modulo_detector_borda, the registered rising-edge detector for pedido_reabastece with synchronous active-low reset.

Test Plan:
- Reset with inputs idle → reg_r = 0, vazio = 1, nivel_baixo = 1, cheio = 0, ack_rolha = 0, erro_falta = 0.
- Pulse pedido_reabastece 7 times, spaced ≥ 3 cycles apart → reg_r steps 15, 30, 45, 60, 75, 90, 99, saturating; cheio = 1 after the 7th.
- From reg_r = 6, hold pedido_rolha until ack and drop it, twice:
  - each ack is exactly one cycle, arriving 2 edges after the request is sampled;
  - reg_r goes 5 and then 4;
  - nivel_baixo rises when reg_r reaches 5.
- From reg_r = 0, raise pedido_rolha → no ack, erro_falta = 1 while reg_r stays 0.
  - Assert limpa_erro with the request still high → erro_falta stays 1 (set wins).
  - Drop the request, then pulse limpa_erro → erro_falta = 0.
- From reg_r = 20, raise pedido_rolha and pedido_reabastece in the same cycle → ack first with reg_r = 19, then reg_r = 34 after the request drops.
- From reg_r = 10, assert rst_n = 0 during DISPENSA → no ack_rolha; next cycle reg_r = 0 and FSM in OCIOSO.
